// File: rtl/reg_file_mod_pkg.sv
// rtl/reg_file_mod_pkg.sv - shared constants and read-port state type for the register file
package reg_file_mod_pkg;

  localparam int RF_WIDTH    = 32;
  localparam int RF_ADDR_LEN = 5;
  localparam int RF_NUM_REGS = 2 ** RF_ADDR_LEN;

  typedef enum logic [1:0] {
    RF_IDLE = 2'd0,
    RF_WAIT = 2'd1,
    RF_RESP = 2'd2
  } rf_state_e;

endpackage

// File: rtl/reg_file_mod_rf_read_port.sv
// rtl/reg_file_mod_rf_read_port.sv - one read port: request FSM, wait-address latch, data/strobe registers
module rf_read_port_mod
  import reg_file_mod_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = RF_ADDR_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_add_i,
  input  logic             busy_i,     // scoreboard bit of rd_add_i before this edge
  input  logic [WIDTH-1:0] reg_val_i,  // stored value of rd_add_i
  input  logic             wr_en_i,    // already masked for r0 by the parent
  input  logic [AW-1:0]    wr_add_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_st_o
);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             st_q, st_d;
  logic             wr_hit;

  // A write landing on the requested register this edge both clears the hazard and supplies the data.
  assign wr_hit = wr_en_i && (wr_add_i == rd_add_i);

  // Next-state, address latch and response data selection.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    st_d    = 1'b0;
    case (state_q)
      RF_WAIT: begin
        if (wr_en_i && (wr_add_i == addr_q)) begin
          state_d = RF_RESP;
          st_d    = 1'b1;
          data_d  = wr_data_i;
        end
      end
      default: begin
        if (!rd_en_i) begin
          state_d = RF_IDLE;
        end else if (busy_i && !wr_hit) begin
          state_d = RF_WAIT;
          addr_d  = rd_add_i;
        end else begin
          state_d = RF_RESP;
          st_d    = 1'b1;
          data_d  = wr_hit ? wr_data_i : reg_val_i;
        end
      end
    endcase
  end

  // State and output registers; reset drops any pending wait without a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      st_q    <= st_d;
    end
  end

  assign rd_data_o = data_q;
  assign rd_st_o   = st_q;

endmodule

// File: rtl/reg_file_mod.sv
// rtl/reg_file_mod.sv - register file with busy scoreboard and two hazard-aware read ports
module reg_file_mod
  import reg_file_mod_pkg::*;
#(
  parameter int WIDTH        = RF_WIDTH,
  parameter int REG_ADDR_LEN = RF_ADDR_LEN,
  parameter int NUM_REGS     = RF_NUM_REGS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] Rd1_add,
  input  logic                    Rd1_en,
  output logic [WIDTH-1:0]        Rd1_data,
  output logic                    Rd1_st,
  input  logic [REG_ADDR_LEN-1:0] Rd2_add,
  input  logic                    Rd2_en,
  output logic [WIDTH-1:0]        Rd2_data,
  output logic                    Rd2_st,
  input  logic [REG_ADDR_LEN-1:0] Wr_add,
  input  logic [WIDTH-1:0]        Wr_data,
  input  logic                    Wr_en,
  input  logic [REG_ADDR_LEN-1:0] Rsv_add,
  input  logic                    Rsv_en,
  output logic [NUM_REGS-1:0]     Busy_out
);

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                wr_eff, rsv_eff;

  // r0 is hardwired: writes and reserves to it are dropped here, so it stays 0 and never busy.
  assign wr_eff  = Wr_en && (Wr_add != '0);
  assign rsv_eff = Rsv_en && (Rsv_add != '0);

  // Storage and scoreboard update; the reserve is applied last so a new producer wins a same-edge tie.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_eff) begin
      regs_d[Wr_add] = Wr_data;
      busy_d[Wr_add] = 1'b0;
    end
    if (rsv_eff) begin
      busy_d[Rsv_add] = 1'b1;
    end
  end

  // Storage and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign Busy_out = busy_q;

  rf_read_port_mod #(.WIDTH(WIDTH), .AW(REG_ADDR_LEN)) u_port1 (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (Rd1_en),
    .rd_add_i  (Rd1_add),
    .busy_i    (busy_q[Rd1_add]),
    .reg_val_i (regs_q[Rd1_add]),
    .wr_en_i   (wr_eff),
    .wr_add_i  (Wr_add),
    .wr_data_i (Wr_data),
    .rd_data_o (Rd1_data),
    .rd_st_o   (Rd1_st)
  );

  rf_read_port_mod #(.WIDTH(WIDTH), .AW(REG_ADDR_LEN)) u_port2 (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (Rd2_en),
    .rd_add_i  (Rd2_add),
    .busy_i    (busy_q[Rd2_add]),
    .reg_val_i (regs_q[Rd2_add]),
    .wr_en_i   (wr_eff),
    .wr_add_i  (Wr_add),
    .wr_data_i (Wr_data),
    .rd_data_o (Rd2_data),
    .rd_st_o   (Rd2_st)
  );

endmodule

// File: tb/tb_reg_file_mod.sv
// tb/tb_reg_file_mod.sv - self-checking bench for reg_file_mod
module tb_reg_file_mod;
  import reg_file_mod_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [RF_ADDR_LEN-1:0] Rd1_add, Rd2_add, Wr_add, Rsv_add;
  logic                   Rd1_en, Rd2_en, Wr_en, Rsv_en;
  logic [RF_WIDTH-1:0]    Rd1_data, Rd2_data, Wr_data;
  logic                   Rd1_st, Rd2_st;
  logic [RF_NUM_REGS-1:0] Busy_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural contents, busy set, and per-port pending read.
  logic [RF_WIDTH-1:0]    m_regs [RF_NUM_REGS];
  logic [RF_NUM_REGS-1:0] m_busy = '0;
  bit                     m_wait [2];
  logic [RF_ADDR_LEN-1:0] m_waddr [2];
  logic [RF_WIDTH-1:0]    m_data [2];
  bit                     m_st [2];

  reg_file_mod dut (
    .clk(clk), .rst(rst),
    .Rd1_add(Rd1_add), .Rd1_en(Rd1_en), .Rd1_data(Rd1_data), .Rd1_st(Rd1_st),
    .Rd2_add(Rd2_add), .Rd2_en(Rd2_en), .Rd2_data(Rd2_data), .Rd2_st(Rd2_st),
    .Wr_add(Wr_add), .Wr_data(Wr_data), .Wr_en(Wr_en),
    .Rsv_add(Rsv_add), .Rsv_en(Rsv_en), .Busy_out(Busy_out)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rst = 1'b0; Rd1_en = 1'b0; Rd2_en = 1'b0; Wr_en = 1'b0; Rsv_en = 1'b0;
    Rd1_add = '0; Rd2_add = '0; Wr_add = '0; Rsv_add = '0; Wr_data = '0;
  endtask

  // Advance one clock edge, updating the model from the inputs currently driven.
  task automatic tick();
    bit en [2];
    logic [RF_ADDR_LEN-1:0] ad [2];
    bit we, rv;
    en[0] = Rd1_en; ad[0] = Rd1_add;
    en[1] = Rd2_en; ad[1] = Rd2_add;
    we = Wr_en && (Wr_add != 0);
    rv = Rsv_en && (Rsv_add != 0);
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        m_st[p] = 0; m_data[p] = '0; m_wait[p] = 0;
      end else if (m_wait[p]) begin
        if (we && Wr_add == m_waddr[p]) begin
          m_wait[p] = 0; m_st[p] = 1; m_data[p] = Wr_data;
        end else m_st[p] = 0;
      end else if (!en[p]) begin
        m_st[p] = 0;
      end else if (we && Wr_add == ad[p]) begin
        m_st[p] = 1; m_data[p] = Wr_data;
      end else if (m_busy[ad[p]]) begin
        m_wait[p] = 1; m_waddr[p] = ad[p]; m_st[p] = 0;
      end else begin
        m_st[p] = 1; m_data[p] = (ad[p] == 0) ? '0 : m_regs[ad[p]];
      end
    end
    if (rst) begin
      for (int i = 0; i < RF_NUM_REGS; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      if (we) begin m_regs[Wr_add] = Wr_data; m_busy[Wr_add] = 1'b0; end
      if (rv) m_busy[Rsv_add] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs(); rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_checks++; if (Rd1_st !== 1'b0 || Rd2_st !== 1'b0) begin n_fail++; $display("FAIL reset_st: got %0b/%0b want 0/0", Rd1_st, Rd2_st); end
    n_checks++; if (Rd1_data !== '0 || Rd2_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", Rd1_data, Rd2_data); end
    n_checks++; if (Busy_out !== '0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", Busy_out); end
  endtask

  task automatic test_idle_read();
    clear_inputs(); Rd1_en = 1'b1; Rd1_add = 5'd5; tick();
    n_checks++; if (Rd1_st !== 1'b1 || Rd1_data !== 32'h0) begin n_fail++; $display("FAIL idle_read: st=%0b data=%h want 1/0", Rd1_st, Rd1_data); end
    Rd1_en = 1'b0; tick();
    n_checks++; if (Rd1_st !== 1'b0) begin n_fail++; $display("FAIL idle_read_single: st=%0b want 0", Rd1_st); end
    n_checks++; if (Busy_out !== '0) begin n_fail++; $display("FAIL idle_read_busy: got %h want 0", Busy_out); end
  endtask

  task automatic test_write_read();
    clear_inputs(); Wr_en = 1'b1; Wr_add = 5'd3; Wr_data = 32'hDEADBEEF; Rd1_en = 1'b1; Rd1_add = 5'd3; tick();
    n_checks++; if (Rd1_st !== 1'b1 || Rd1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass: st=%0b data=%h want 1/deadbeef", Rd1_st, Rd1_data); end
    Wr_en = 1'b0; Wr_data = '0; tick();
    n_checks++; if (Rd1_st !== 1'b1 || Rd1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_after_write: st=%0b data=%h want 1/deadbeef", Rd1_st, Rd1_data); end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    for (int i = 1; i <= 4; i++) begin Wr_en = 1'b1; Wr_add = 5'(i + 10); Wr_data = 32'h1000 * i + i; tick(); end
    clear_inputs(); Rd1_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      Rd1_add = 5'(i + 10); tick();
      n_checks++; if (Rd1_st !== 1'b1 || Rd1_data !== 32'h1000 * i + i) begin n_fail++; $display("FAIL back_to_back_%0d: st=%0b data=%h want 1/%h", i, Rd1_st, Rd1_data, 32'h1000 * i + i); end
    end
    Rd1_en = 1'b0; tick();
  endtask

  task automatic test_busy_wait();
    clear_inputs(); Rsv_en = 1'b1; Rsv_add = 5'd7; tick();
    n_checks++; if (Busy_out[7] !== 1'b1) begin n_fail++; $display("FAIL busy_set: got %0b want 1", Busy_out[7]); end
    clear_inputs(); Rd2_en = 1'b1; Rd2_add = 5'd7; tick(); Rd2_en = 1'b0;
    n_checks++; if (Rd2_st !== 1'b0) begin n_fail++; $display("FAIL wait_c1: st=%0b want 0", Rd2_st); end
    tick();
    n_checks++; if (Rd2_st !== 1'b0) begin n_fail++; $display("FAIL wait_c2: st=%0b want 0", Rd2_st); end
    tick();
    n_checks++; if (Rd2_st !== 1'b0) begin n_fail++; $display("FAIL wait_c3: st=%0b want 0", Rd2_st); end
    Wr_en = 1'b1; Wr_add = 5'd7; Wr_data = 32'h12345678; tick(); Wr_en = 1'b0;
    n_checks++; if (Rd2_st !== 1'b1 || Rd2_data !== 32'h12345678) begin n_fail++; $display("FAIL wait_release: st=%0b data=%h want 1/12345678", Rd2_st, Rd2_data); end
    n_checks++; if (Busy_out[7] !== 1'b0) begin n_fail++; $display("FAIL busy_clear: got %0b want 0", Busy_out[7]); end
    tick();
    n_checks++; if (Rd2_st !== 1'b0) begin n_fail++; $display("FAIL wait_one_strobe: st=%0b want 0", Rd2_st); end
  endtask

  task automatic test_both_ports();
    clear_inputs(); Rsv_en = 1'b1; Rsv_add = 5'd9; tick();
    clear_inputs(); Rd1_en = 1'b1; Rd1_add = 5'd9; Rd2_en = 1'b1; Rd2_add = 5'd9; tick();
    clear_inputs(); tick();
    n_checks++; if (Rd1_st !== 1'b0 || Rd2_st !== 1'b0) begin n_fail++; $display("FAIL both_wait: st=%0b/%0b want 0/0", Rd1_st, Rd2_st); end
    Wr_en = 1'b1; Wr_add = 5'd9; Wr_data = 32'hA5A5A5A5; tick(); Wr_en = 1'b0;
    n_checks++; if (Rd1_st !== 1'b1 || Rd2_st !== 1'b1) begin n_fail++; $display("FAIL both_release_st: st=%0b/%0b want 1/1", Rd1_st, Rd2_st); end
    n_checks++; if (Rd1_data !== 32'hA5A5A5A5 || Rd2_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL both_release_data: %h/%h want a5a5a5a5", Rd1_data, Rd2_data); end
  endtask

  task automatic test_r0();
    clear_inputs(); Wr_en = 1'b1; Wr_add = 5'd0; Wr_data = 32'hFFFFFFFF; Rsv_en = 1'b1; Rsv_add = 5'd0;
    Rd1_en = 1'b1; Rd1_add = 5'd0; tick();
    n_checks++; if (Rd1_st !== 1'b1 || Rd1_data !== 32'h0) begin n_fail++; $display("FAIL r0_no_bypass: st=%0b data=%h want 1/0", Rd1_st, Rd1_data); end
    n_checks++; if (Busy_out[0] !== 1'b0) begin n_fail++; $display("FAIL r0_busy: got %0b want 0", Busy_out[0]); end
    clear_inputs(); Rd1_en = 1'b1; Rd1_add = 5'd0; tick(); Rd1_en = 1'b0;
    n_checks++; if (Rd1_st !== 1'b1 || Rd1_data !== 32'h0) begin n_fail++; $display("FAIL r0_read: st=%0b data=%h want 1/0", Rd1_st, Rd1_data); end
  endtask

  task automatic test_same_edge_rsv_wr();
    clear_inputs(); Rsv_en = 1'b1; Rsv_add = 5'd10; Wr_en = 1'b1; Wr_add = 5'd10; Wr_data = 32'h55;
    Rd2_en = 1'b1; Rd2_add = 5'd20; tick();
    clear_inputs();
    n_checks++; if (Busy_out[10] !== 1'b1) begin n_fail++; $display("FAIL rsv_wins: busy=%0b want 1", Busy_out[10]); end
    Rsv_en = 1'b1; Rsv_add = 5'd21; Rd1_en = 1'b1; Rd1_add = 5'd21; tick(); clear_inputs();
    n_checks++; if (Rd1_st !== 1'b1) begin n_fail++; $display("FAIL rsv_same_edge_read: st=%0b want 1", Rd1_st); end
    Wr_en = 1'b1; Wr_add = 5'd10; Wr_data = 32'h66; tick();
    Wr_add = 5'd21; tick(); clear_inputs();
  endtask

  task automatic test_reset_abort();
    clear_inputs(); Rsv_en = 1'b1; Rsv_add = 5'd4; tick();
    clear_inputs(); Rd1_en = 1'b1; Rd1_add = 5'd4; tick();
    clear_inputs(); rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (Rd1_st !== 1'b0 || Busy_out !== '0) begin n_fail++; $display("FAIL abort_reset: st=%0b busy=%h want 0/0", Rd1_st, Busy_out); end
    Wr_en = 1'b1; Wr_add = 5'd4; Wr_data = 32'h0BADCAFE; tick(); Wr_en = 1'b0;
    n_checks++; if (Rd1_st !== 1'b0) begin n_fail++; $display("FAIL abort_no_strobe: st=%0b want 0", Rd1_st); end
    Rd1_en = 1'b1; Rd1_add = 5'd4; tick(); Rd1_en = 1'b0;
    n_checks++; if (Rd1_st !== 1'b1 || Rd1_data !== 32'h0BADCAFE) begin n_fail++; $display("FAIL abort_later_read: st=%0b data=%h want 1/0badcafe", Rd1_st, Rd1_data); end
  endtask

  task automatic test_random();
    clear_inputs(); rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      Rd1_en  = ($urandom_range(0, 1) == 1);
      Rd2_en  = ($urandom_range(0, 1) == 1);
      Wr_en   = ($urandom_range(0, 9) < 4);
      Rsv_en  = ($urandom_range(0, 9) < 3);
      Rd1_add = 5'($urandom_range(0, 7));
      Rd2_add = 5'($urandom_range(0, 7));
      Wr_add  = 5'($urandom_range(0, 7));
      Rsv_add = 5'($urandom_range(0, 7));
      Wr_data = $urandom;
      tick();
      n_checks++; if (Rd1_st !== m_st[0] || Rd1_data !== m_data[0]) begin n_fail++; $display("FAIL rand_port1 cyc %0d: st=%0b data=%h want %0b/%h", c, Rd1_st, Rd1_data, m_st[0], m_data[0]); end
      n_checks++; if (Rd2_st !== m_st[1] || Rd2_data !== m_data[1]) begin n_fail++; $display("FAIL rand_port2 cyc %0d: st=%0b data=%h want %0b/%h", c, Rd2_st, Rd2_data, m_st[1], m_data[1]); end
      n_checks++; if (Busy_out !== m_busy) begin n_fail++; $display("FAIL rand_busy cyc %0d: got %h want %h", c, Busy_out, m_busy); end
    end
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < RF_NUM_REGS; i++) m_regs[i] = '0;
    clear_inputs();
    test_reset();
    test_idle_read();
    test_write_read();
    test_back_to_back();
    test_busy_wait();
    test_both_ports();
    test_r0();
    test_same_edge_rsv_wr();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
